register_file_rename: RTL and testbench
=======================================

Name: register_file_rename

Overview:
- Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer's commit port and beside the issue unit.
- Holds committed values for x0..x31. Each register also tracks whether a younger in-flight instruction will write it, and which ROB entry that is.
- The issue unit reads source operands combinationally and gets either a committed value or a ROB tag to wait on. Issue renames the destination; commit retires values and clears busy bits.

Parameters:
- REG_NUM, 32, number of architectural registers; index 0 is hardwired zero.
- ROB_W, 6, ROB index width (64-entry ROB).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; state frozen when low
- flush  in  1  pipeline flush from ROB (mispredict)
- issue_valid  in  1  an instruction is being issued this cycle
- issue_rd  in  5  destination register of the issued instruction
- issue_rob_index  in  ROB_W  ROB entry allocated to the issued instruction
- issue_rs1  in  5  source register 1 index
- issue_rs2  in  5  source register 2 index
- rs1_busy  out  1  rs1 awaits an in-flight producer
- rs1_tag  out  ROB_W  ROB entry producing rs1; 0 when not busy
- rs1_value  out  XLEN  committed or forwarded value of rs1; 0 when busy
- rs2_busy  out  1  same as rs1_busy, for rs2
- rs2_tag  out  ROB_W  same as rs1_tag, for rs2
- rs2_value  out  XLEN  same as rs1_value, for rs2
- commit_valid  in  1  ROB commits a register write this cycle
- commit_index  in  ROB_W  ROB entry being committed
- commit_rd  in  5  destination register of the commit
- commit_value  in  XLEN  value being written

Behaviour:
- State per register: value[XLEN], busy[1], tag[ROB_W].
- Reset (rst high at posedge):
  - All value, busy and tag bits become 0; issue and commit inputs are ignored that cycle.
  - After reset, every read returns value 0, busy 0, tag 0.
- rdy low: no state changes; the read outputs stay valid combinationally.
- Read path (combinational, zero latency), for each of rs1/rs2 with index r:
  - r == 0: value 0, busy 0, tag 0.
  - Forwarding: if commit_valid and commit_rd == r != 0 and busy[r] and tag[r] == commit_index, output busy 0, tag 0, value commit_value.
  - Otherwise: busy = busy[r]; tag = busy[r] ? tag[r] : 0; value = busy[r] ? 0 : value[r].
  - Reads reflect state before this cycle's issue rename. An instruction with rs == rd never sees its own tag.
- Commit write (posedge, rdy high, commit_valid, commit_rd != 0):
  - value[commit_rd] <= commit_value unconditionally.
  - busy[commit_rd] <= 0 only if tag[commit_rd] == commit_index. A mismatch means a younger writer exists, so busy and tag are kept.
- Issue rename (posedge, rdy high, issue_valid, issue_rd != 0, flush low):
  - busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_index.
- Same-cycle issue and commit to the same rd: the issue rename wins, so busy stays 1 with the new tag. The commit value is still written.
- Flush (posedge, rdy high, flush high):
  - All busy bits <= 0 and all tags <= 0.
  - A commit presented in the same cycle is still written, because the mispredicted branch commits in the flush cycle.
  - Issue in that cycle is ignored.
- x0: writes and renames to register 0 are discarded; busy[0] is never set.
- Tag wrap-around: tags are plain ROB indices compared by equality only; 63 followed by 0 needs no special handling.
- Fully synchronous single clock domain. No internal pipeline; the block holds no handshake state.

Test Plan:
- Reset, then read rs1=5 and rs2=0 -> busy 0, tag 0, value 0 on both.
- Commit rd=3, index 7, value 0x1234 while x3 is not busy -> next cycle rs1=3 reads value 0x1234, busy 0.
- Issue rd=4 with tag 10, then read rs1=4 -> busy 1, tag 10. Commit index 10, rd=4, value 0xAB while reading rs1=4 in the same cycle -> that cycle reads busy 0, value 0xAB (forward). Next cycle x4 reads busy 0, value 0xAB.
- Issue rd=6 tag 2, then issue rd=6 tag 9, then commit index 2, rd=6, value 0x55 -> x6 stays busy with tag 9. Commit index 9, value 0x66 -> busy 0, value 0x66.
- Rename x1..x5 to tags 1..5; assert flush together with commit index 1, rd=1, value 0xF0, and issue rd=7 tag 6 -> all busy 0, x1 = 0xF0, x7 not busy.
- Issue rd=0 with tag 3 and commit rd=0 with value 0xFF -> x0 reads busy 0, value 0. With rdy=0, issue rd=8 tag 4 -> x8 stays not busy.

Source files
------------

// File: rtl/register_file_rename.sv
// Architectural register file with per-register rename tags: committed values plus
// busy/tag tracking of the youngest in-flight writer, with commit-to-read forwarding.
module register_file_rename #(
    parameter int REG_NUM = 32,
    parameter int ROB_W   = 6,
    parameter int XLEN    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [ROB_W-1:0] issue_rob_index,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    output logic             rs1_busy,
    output logic [ROB_W-1:0] rs1_tag,
    output logic [XLEN-1:0]  rs1_value,
    output logic             rs2_busy,
    output logic [ROB_W-1:0] rs2_tag,
    output logic [XLEN-1:0]  rs2_value,
    input  logic             commit_valid,
    input  logic [ROB_W-1:0] commit_index,
    input  logic [4:0]       commit_rd,
    input  logic [XLEN-1:0]  commit_value
);

    logic [XLEN-1:0]  value_q [REG_NUM];
    logic [XLEN-1:0]  value_d [REG_NUM];
    logic             busy_q  [REG_NUM];
    logic             busy_d  [REG_NUM];
    logic [ROB_W-1:0] tag_q   [REG_NUM];
    logic [ROB_W-1:0] tag_d   [REG_NUM];

    logic [4:0]       rd_idx   [2];
    logic             rd_busy  [2];
    logic [ROB_W-1:0] rd_tag   [2];
    logic [XLEN-1:0]  rd_value [2];

    assign rd_idx[0] = issue_rs1;
    assign rd_idx[1] = issue_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                rd_busy[gi]  = 1'b0;
                rd_tag[gi]   = '0;
                rd_value[gi] = '0;
                if (rd_idx[gi] != 5'd0) begin
                    // The producer retiring right now resolves the operand without a bubble.
                    if (commit_valid && commit_rd == rd_idx[gi] && busy_q[rd_idx[gi]]
                            && tag_q[rd_idx[gi]] == commit_index) begin
                        rd_value[gi] = commit_value;
                    end else if (busy_q[rd_idx[gi]]) begin
                        rd_busy[gi] = 1'b1;
                        rd_tag[gi]  = tag_q[rd_idx[gi]];
                    end else begin
                        rd_value[gi] = value_q[rd_idx[gi]];
                    end
                end
            end
        end
    endgenerate

    assign rs1_busy  = rd_busy[0];
    assign rs1_tag   = rd_tag[0];
    assign rs1_value = rd_value[0];
    assign rs2_busy  = rd_busy[1];
    assign rs2_tag   = rd_tag[1];
    assign rs2_value = rd_value[1];

    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (rdy) begin
            if (commit_valid && commit_rd != 5'd0) begin
                value_d[commit_rd] = commit_value;
                // A tag mismatch means a younger writer still owns the register.
                if (tag_q[commit_rd] == commit_index) begin
                    busy_d[commit_rd] = 1'b0;
                end
            end
            if (flush) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    busy_d[i] = 1'b0;
                    tag_d[i]  = '0;
                end
            end else if (issue_valid && issue_rd != 5'd0) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_rob_index;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                busy_q[i]  <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_register_file_rename.sv
// Directed, table-driven bench for register_file_rename: each row drives one cycle of
// inputs and lists the combinational read results expected before that cycle's edge.
module tb_register_file_rename;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, issue_valid, commit_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2, commit_rd;
    logic [5:0]  issue_rob_index, commit_index;
    logic [31:0] commit_value;
    logic        rs1_busy, rs2_busy;
    logic [5:0]  rs1_tag, rs2_tag;
    logic [31:0] rs1_value, rs2_value;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_rename dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_index(issue_rob_index),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_value(rs1_value),
        .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_value(rs2_value),
        .commit_valid(commit_valid), .commit_index(commit_index),
        .commit_rd(commit_rd), .commit_value(commit_value)
    );

    typedef struct {
        logic        rdy, fl, iv;
        logic [4:0]  ird;
        logic [5:0]  irob;
        logic        cv;
        logic [5:0]  cidx;
        logic [4:0]  crd;
        logic [31:0] cval;
        logic [4:0]  rs1, rs2;
        logic        b1;
        logic [5:0]  t1;
        logic [31:0] v1;
        logic        b2;
        logic [5:0]  t2;
        logic [31:0] v2;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input int ird,
                                input int irob, input logic cv, input int cidx, input int crd,
                                input logic [31:0] cval, input int rs1, input int rs2,
                                input logic b1, input int t1, input logic [31:0] v1,
                                input logic b2, input int t2, input logic [31:0] v2);
        vec_t v;
        v.rdy = r; v.fl = f; v.iv = iv; v.ird = ird[4:0]; v.irob = irob[5:0];
        v.cv = cv; v.cidx = cidx[5:0]; v.crd = crd[4:0]; v.cval = cval;
        v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0];
        v.b1 = b1; v.t1 = t1[5:0]; v.v1 = v1;
        v.b2 = b2; v.t2 = t2[5:0]; v.v2 = v2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reads(input string tag, input logic b1, input logic [5:0] t1,
                               input logic [31:0] v1, input logic b2, input logic [5:0] t2,
                               input logic [31:0] v2);
        check({tag, " rs1_busy"}, {31'd0, rs1_busy}, {31'd0, b1});
        check({tag, " rs1_tag"}, {26'd0, rs1_tag}, {26'd0, t1});
        check({tag, " rs1_value"}, rs1_value, v1);
        check({tag, " rs2_busy"}, {31'd0, rs2_busy}, {31'd0, b2});
        check({tag, " rs2_tag"}, {26'd0, rs2_tag}, {26'd0, t2});
        check({tag, " rs2_value"}, rs2_value, v2);
    endtask

    task automatic drive(input vec_t v);
        rdy = v.rdy; flush = v.fl;
        issue_valid = v.iv; issue_rd = v.ird; issue_rob_index = v.irob;
        commit_valid = v.cv; commit_index = v.cidx; commit_rd = v.crd; commit_value = v.cval;
        issue_rs1 = v.rs1; issue_rs2 = v.rs2;
    endtask

    initial begin
        //                rdy fl iv ird irob cv cidx crd cval       rs1 rs2  b1 t1 v1          b2 t2 v2
        vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0,  0, 32'h0,     5, 0,  0, 0, 32'h0,     0, 0, 32'h0);
        vecs[1]  = mk(1, 0, 0, 0, 0,  1, 7,  3, 32'h1234,  3, 3,  0, 0, 32'h0,     0, 0, 32'h0);
        vecs[2]  = mk(1, 0, 1, 4, 10, 0, 0,  0, 32'h0,     3, 4,  0, 0, 32'h1234,  0, 0, 32'h0);
        vecs[3]  = mk(1, 0, 0, 0, 0,  0, 0,  0, 32'h0,     4, 3,  1, 10, 32'h0,    0, 0, 32'h1234);
        vecs[4]  = mk(1, 0, 0, 0, 0,  1, 10, 4, 32'hAB,    4, 4,  0, 0, 32'hAB,    0, 0, 32'hAB);
        vecs[5]  = mk(1, 0, 1, 6, 2,  0, 0,  0, 32'h0,     4, 6,  0, 0, 32'hAB,    0, 0, 32'h0);
        vecs[6]  = mk(1, 0, 1, 6, 9,  0, 0,  0, 32'h0,     6, 0,  1, 2, 32'h0,     0, 0, 32'h0);
        vecs[7]  = mk(1, 0, 0, 0, 0,  1, 2,  6, 32'h55,    6, 6,  1, 9, 32'h0,     1, 9, 32'h0);
        vecs[8]  = mk(1, 0, 0, 0, 0,  1, 9,  6, 32'h66,    6, 6,  0, 0, 32'h66,    0, 0, 32'h66);
        vecs[9]  = mk(1, 0, 1, 1, 1,  0, 0,  0, 32'h0,     6, 1,  0, 0, 32'h66,    0, 0, 32'h0);
        vecs[10] = mk(1, 0, 1, 2, 2,  0, 0,  0, 32'h0,     1, 0,  1, 1, 32'h0,     0, 0, 32'h0);
        vecs[11] = mk(1, 0, 1, 3, 3,  0, 0,  0, 32'h0,     2, 3,  1, 2, 32'h0,     0, 0, 32'h1234);
        vecs[12] = mk(1, 0, 1, 4, 4,  0, 0,  0, 32'h0,     3, 4,  1, 3, 32'h0,     0, 0, 32'hAB);
        vecs[13] = mk(1, 0, 1, 5, 5,  0, 0,  0, 32'h0,     4, 1,  1, 4, 32'h0,     1, 1, 32'h0);
        vecs[14] = mk(1, 1, 1, 7, 6,  1, 1,  1, 32'hF0,    5, 1,  1, 5, 32'h0,     0, 0, 32'hF0);
        vecs[15] = mk(1, 0, 0, 0, 0,  0, 0,  0, 32'h0,     1, 7,  0, 0, 32'hF0,    0, 0, 32'h0);
        vecs[16] = mk(1, 0, 1, 0, 3,  1, 0,  0, 32'hFF,    5, 3,  0, 0, 32'h0,     0, 0, 32'h1234);
        vecs[17] = mk(0, 0, 1, 8, 4,  1, 0,  3, 32'h999,   0, 3,  0, 0, 32'h0,     0, 0, 32'h1234);
        vecs[18] = mk(1, 0, 0, 0, 0,  0, 0,  0, 32'h0,     8, 3,  0, 0, 32'h0,     0, 0, 32'h1234);
        vecs[19] = mk(1, 0, 1, 9, 63, 0, 0,  0, 32'h0,     9, 0,  0, 0, 32'h0,     0, 0, 32'h0);
        vecs[20] = mk(1, 0, 1, 10, 0, 0, 0,  0, 32'h0,     9, 10, 1, 63, 32'h0,    0, 0, 32'h0);
        vecs[21] = mk(1, 0, 0, 0, 0,  1, 0,  10, 32'h77,   10, 9, 0, 0, 32'h77,    1, 63, 32'h0);
        vecs[22] = mk(1, 0, 0, 0, 0,  0, 0,  0, 32'h0,     10, 9, 0, 0, 32'h77,    1, 63, 32'h0);
        vecs[23] = mk(1, 0, 1, 9, 5,  1, 63, 9, 32'h88,    9, 9,  0, 0, 32'h88,    0, 0, 32'h88);
        vecs[24] = mk(1, 0, 0, 0, 0,  0, 0,  0, 32'h0,     9, 9,  1, 5, 32'h0,     1, 5, 32'h0);

        rst = 1'b1;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            check_reads($sformatf("v%0d", i), vecs[i].b1, vecs[i].t1, vecs[i].v1,
                        vecs[i].b2, vecs[i].t2, vecs[i].v2);
            $display("v%0d rs1=%0d b=%0d t=%0d v=0x%0h | rs2=%0d b=%0d t=%0d v=0x%0h", i,
                     vecs[i].rs1, rs1_busy, rs1_tag, rs1_value,
                     vecs[i].rs2, rs2_busy, rs2_tag, rs2_value);
            @(negedge clk);
        end

        // Reset with issue and commit pending must clear everything and ignore both.
        rst = 1'b1;
        drive(mk(1, 0, 1, 11, 12, 1, 5, 10, 32'h5, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0));
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 9, 10, 0, 0, 32'h0, 0, 0, 32'h0));
        #1;
        check_reads("rst_a", 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        $display("rst_a rs1=9 b=%0d v=0x%0h | rs2=10 b=%0d v=0x%0h",
                 rs1_busy, rs1_value, rs2_busy, rs2_value);
        issue_rs1 = 5'd11;
        issue_rs2 = 5'd6;
        #1;
        check_reads("rst_b", 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        $display("rst_b rs1=11 b=%0d t=%0d | rs2=6 v=0x%0h", rs1_busy, rs1_tag, rs2_value);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
